// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   - Byte-mask codes as presented on dmDataWIn (low-justified).
//   - MMIO register byte offsets from the MMIO base.
//   - STATUS register bit indices.
//   - Helpers for access alignment and load-data rotation.
package data_mem_responder_pkg;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    localparam logic [15:0] OFF_CYCLE_LO   = 16'h0000;
    localparam logic [15:0] OFF_CYCLE_HI   = 16'h0004;
    localparam logic [15:0] OFF_CMP        = 16'h0008;
    localparam logic [15:0] OFF_STATUS     = 16'h000C;
    localparam logic [15:0] OFF_FAULT_ADDR = 16'h0010;

    localparam int STATUS_TIMER_BIT = 0;
    localparam int STATUS_FAULT_BIT = 1;

    // Mask 0000 (size unknown) is never misaligned; unknown codes always are.
    function automatic logic is_misaligned(input logic [3:0] mask, input logic [1:0] off);
        logic bad;
        case (mask)
            4'b0000: bad = 1'b0;
            MASK_B:  bad = 1'b0;
            MASK_H:  bad = off[0];
            MASK_W:  bad = (off != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Rotate right by whole bytes so the addressed byte lands in [7:0].
    function automatic logic [31:0] rotr_bytes(input logic [31:0] word, input logic [1:0] off);
        return 32'({word, word} >> {off, 3'b000});
    endfunction

endpackage

// File: rtl/data_mem_responder_mmio.sv
// MMIO register file for the data-memory responder: free-running 64-bit
// cycle counter, compare register, STATUS (RW1C) and FAULT_ADDR, plus the
// read mux for the region.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   wr_en             accepted (aligned, full-word) MMIO write this cycle
//   word_off          addr[15:2] within the MMIO region
//   wr_data           write data (already lane-aligned, full word)
//   fault_evt         current access faults; sets STATUS[1], captures addr
//   fault_addr        address of the current access
//   rd_data           register selected by word_off (0 if unmapped)
//   mapped            word_off selects an implemented register
//   timer_irq         STATUS[0]
module dm_mmio_regs
    import data_mem_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [13:0] word_off,
    input  logic [31:0] wr_data,
    input  logic        fault_evt,
    input  logic [31:0] fault_addr,
    output logic [31:0] rd_data,
    output logic        mapped,
    output logic        timer_irq
);
    logic [63:0] cycle;
    logic [31:0] cmp;
    logic [1:0]  status;
    logic [31:0] fault_addr_q;
    logic [15:0] byte_off;
    logic        sel_lo, sel_hi, sel_cmp, sel_status, sel_faddr;
    logic        timer_hit;
    logic [1:0]  status_clr;
    logic [1:0]  status_next;

    assign byte_off   = {word_off, 2'b00};
    assign sel_lo     = (byte_off == OFF_CYCLE_LO);
    assign sel_hi     = (byte_off == OFF_CYCLE_HI);
    assign sel_cmp    = (byte_off == OFF_CMP);
    assign sel_status = (byte_off == OFF_STATUS);
    assign sel_faddr  = (byte_off == OFF_FAULT_ADDR);
    assign mapped     = sel_lo | sel_hi | sel_cmp | sel_status | sel_faddr;

    // CMP == 0 disarms the timer.
    assign timer_hit  = (cycle[31:0] == cmp) && (cmp != 32'd0);
    assign status_clr = (wr_en && sel_status) ? wr_data[1:0] : 2'b00;

    // Set has priority over a same-cycle write-one-to-clear.
    always_comb begin
        status_next = status & ~status_clr;
        if (timer_hit) status_next[STATUS_TIMER_BIT] = 1'b1;
        if (fault_evt) status_next[STATUS_FAULT_BIT] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle        <= '0;
            cmp          <= '0;
            status       <= '0;
            fault_addr_q <= '0;
        end else begin
            cycle  <= cycle + 64'd1;
            status <= status_next;
            if (wr_en && sel_cmp) cmp <= wr_data;
            if (fault_evt) fault_addr_q <= fault_addr;
        end
    end

    always_comb begin
        rd_data = '0;
        if (sel_lo)     rd_data = cycle[31:0];
        if (sel_hi)     rd_data = cycle[63:32];
        if (sel_cmp)    rd_data = cmp;
        if (sel_status) rd_data = {30'd0, status};
        if (sel_faddr)  rd_data = fault_addr_q;
    end

    assign timer_irq = status[STATUS_TIMER_BIT];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder behind the MEM-stage data port. Decodes the access
// (RAM / MMIO / unmapped), aligns low-justified mask and data to the byte
// lane, commits writes to a word RAM or the MMIO registers, and returns the
// addressed word rotated so the addressed byte sits in [7:0]. Zero-latency
// reads; writes commit on the posedge of the cycle they are presented.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   dmAddrIn       byte address
//   dmWeIn/dmReIn  write / read strobes (both high = write, read data 0)
//   dmDataWIn      low-justified byte mask (0001/0011/1111, 0000 = unknown)
//   dmWDataIn      low-justified write data
//   dmRDataOut     rotated read data (0 when idle, writing or unmapped)
//   faultOut       current access is unmapped or misaligned
//   timerIrqOut    timer pending (STATUS[0])
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          BUS_W       = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] dmAddrIn,
    input  logic             dmWeIn,
    input  logic             dmReIn,
    input  logic [3:0]       dmDataWIn,
    input  logic [BUS_W-1:0] dmWDataIn,
    output logic [BUS_W-1:0] dmRDataOut,
    output logic             faultOut,
    output logic             timerIrqOut
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [BUS_W-1:0] ram [DEPTH_WORDS];

    logic [1:0]       off;
    logic             active, misaligned, ram_hit, mmio_region, mmio_mapped;
    logic             mapped, mmio_mask_bad, fault;
    logic [3:0]       lane_mask;
    logic [BUS_W-1:0] lane_data;
    logic             ram_we, mmio_we;
    logic [IDX_W-1:0] ram_idx;
    logic [BUS_W-1:0] mmio_word, rd_word;

    assign off         = dmAddrIn[1:0];
    assign active      = dmWeIn | dmReIn;
    assign misaligned  = is_misaligned(dmDataWIn, off);
    assign ram_hit     = dmAddrIn[BUS_W-1:2] < (BUS_W-2)'(DEPTH_WORDS);
    assign mmio_region = dmAddrIn[BUS_W-1:16] == MMIO_BASE[31:16];
    assign mapped      = ram_hit | (mmio_region & mmio_mapped);
    // MMIO registers are only writable as whole words.
    assign mmio_mask_bad = dmWeIn & mmio_region & mmio_mapped & (dmDataWIn != MASK_W);
    assign fault       = active & (~mapped | misaligned | mmio_mask_bad);
    assign faultOut    = fault;

    assign lane_mask = dmDataWIn << off;
    assign lane_data = dmWDataIn << {off, 3'b000};
    assign ram_idx   = dmAddrIn[IDX_W+1:2];

    // Gating with rst drops a write that is in flight while reset is held;
    // the RAM array itself is never cleared.
    assign ram_we  = rst & dmWeIn & ram_hit & ~fault;
    assign mmio_we = dmWeIn & mmio_region & ~fault;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask[b]) ram[ram_idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

    dm_mmio_regs u_mmio (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (mmio_we),
        .word_off   (dmAddrIn[15:2]),
        .wr_data    (lane_data),
        .fault_evt  (fault),
        .fault_addr (dmAddrIn),
        .rd_data    (mmio_word),
        .mapped     (mmio_mapped),
        .timer_irq  (timerIrqOut)
    );

    always_comb begin
        rd_word = '0;
        if (ram_hit) rd_word = ram[ram_idx];
        else if (mmio_region && mmio_mapped) rd_word = mmio_word;
    end

    // A combined read+write is treated as a write: no read data.
    assign dmRDataOut = (dmReIn && !dmWeIn) ? rotr_bytes(rd_word, off) : '0;

endmodule
